// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// A request transfers on a cycle where Fo_imemReq && Fi_imemReady; its single response arrives later as a one-cycle Fi_imemRvalid pulse with Fi_imemRdata.
interface fetch_stage_if;
    logic        Fo_imemReq;
    logic [31:0] Fo_imemAddr;
    logic        Fi_imemReady;
    logic        Fi_imemRvalid;
    logic [31:0] Fi_imemRdata;

    modport master (
        output Fo_imemReq,
        output Fo_imemAddr,
        input  Fi_imemReady,
        input  Fi_imemRvalid,
        input  Fi_imemRdata
    );

    modport slave (
        input  Fo_imemReq,
        input  Fo_imemAddr,
        output Fi_imemReady,
        output Fi_imemRvalid,
        output Fi_imemRdata
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps one imem request in flight,
// applies E/D redirects and drives the F/D pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset_x,
    input  logic         Fi_stall,
    input  logic         Di_stall,
    input  logic         Di_flush,
    input  logic         Ei_redirect,
    input  logic [31:0]  Ei_targetPC,
    input  logic         Di_jal,
    input  logic [31:0]  Di_jalTarget,
    fetch_stage_if.master imem,
    output logic [31:0]  Do_instr,
    output logic [31:0]  Do_pc,
    output logic [31:0]  Do_pcPlus4,
    output logic         Do_valid,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] hold_instr, hold_pc;
    logic        hold_load;
    logic        fetch_req;
    logic        deliver;
    logic [31:0] deliver_instr, deliver_pc;

    // E-stage redirect is older in program order, so it overrides a D-stage jal.
    logic        redirect;
    logic [31:0] target;
    assign redirect = Ei_redirect | Di_jal;
    assign target   = Ei_redirect ? Ei_targetPC : Di_jalTarget;

    assign imem.Fo_imemReq  = fetch_req;
    assign imem.Fo_imemAddr = {pc[31:2], 2'b00};
    assign state_dbg        = state;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            hold_instr <= NOP_INSTR;
            hold_pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (hold_load) begin
                hold_instr <= imem.Fi_imemRdata;
                hold_pc    <= pc;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        hold_load  = 1'b0;
        case (state)
            S_REQ: begin
                if (redirect)
                    pc_next = target;
                if (fetch_req && imem.Fi_imemReady)
                    state_next = redirect ? S_DISCARD : S_WAIT;
            end
            S_WAIT: begin
                if (imem.Fi_imemRvalid) begin
                    if (redirect) begin
                        pc_next    = target;
                        state_next = S_REQ;
                    end else if (!Di_stall) begin
                        pc_next    = pc + 32'd4;
                        state_next = S_REQ;
                    end else begin
                        hold_load  = 1'b1;
                        state_next = S_HOLD;
                    end
                end else if (redirect) begin
                    pc_next    = target;
                    state_next = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // The stale response must drain before a new request may issue.
                if (redirect)
                    pc_next = target;
                if (imem.Fi_imemRvalid)
                    state_next = S_REQ;
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = S_REQ;
                end else if (!Di_stall) begin
                    pc_next    = pc + 32'd4;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        fetch_req     = reset_x && (state == S_REQ) && !Fi_stall;
        deliver       = 1'b0;
        deliver_instr = imem.Fi_imemRdata;
        deliver_pc    = pc;
        case (state)
            S_WAIT: deliver = imem.Fi_imemRvalid && !redirect && !Di_stall;
            S_HOLD: begin
                deliver       = !redirect && !Di_stall;
                deliver_instr = hold_instr;
                deliver_pc    = hold_pc;
            end
            default: deliver = 1'b0;
        endcase
    end

    // F/D register: flush beats stall beats delivery; otherwise a bubble.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            Do_instr   <= NOP_INSTR;
            Do_pc      <= 32'd0;
            Do_pcPlus4 <= 32'd0;
            Do_valid   <= 1'b0;
        end else if (Di_flush) begin
            Do_valid <= 1'b0;
            Do_instr <= NOP_INSTR;
        end else if (!Di_stall) begin
            if (deliver) begin
                Do_instr   <= deliver_instr;
                Do_pc      <= deliver_pc;
                Do_pcPlus4 <= deliver_pc + 32'd4;
                Do_valid   <= 1'b1;
            end else begin
                Do_valid <= 1'b0;
                Do_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against an
// address-tagged memory and a program-order PC model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_x;
    logic        fi_stall, di_stall, di_flush;
    logic        ei_redirect, di_jal;
    logic [31:0] ei_target, di_jal_target;
    logic [31:0] do_instr, do_pc, do_pc_plus4;
    logic        do_valid;
    logic [1:0]  state_dbg;

    fetch_stage_if imem();

    fetch_stage dut (
        .clk          (clk),
        .reset_x      (reset_x),
        .Fi_stall     (fi_stall),
        .Di_stall     (di_stall),
        .Di_flush     (di_flush),
        .Ei_redirect  (ei_redirect),
        .Ei_targetPC  (ei_target),
        .Di_jal       (di_jal),
        .Di_jalTarget (di_jal_target),
        .imem         (imem),
        .Do_instr     (do_instr),
        .Do_pc        (do_pc),
        .Do_pcPlus4   (do_pc_plus4),
        .Do_valid     (do_valid),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory model: one pending request, response after a random latency.
    bit          mem_auto, mem_busy, prev_busy;
    int          mem_ready_pct, mem_max_lat, mem_lat;
    logic [31:0] mem_addr;

    // Values seen just before the most recent rising edge.
    logic        s_req, s_ready, s_rvalid, s_redirect, s_di_stall;
    logic [31:0] s_addr, s_target;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ {a[31:16], a[31:16]};
    endfunction

    task automatic drive_mem();
        imem.Fi_imemRvalid = mem_busy && (mem_lat == 0);
        imem.Fi_imemRdata  = imem.Fi_imemRvalid ? tag(mem_addr) : $urandom();
        imem.Fi_imemReady  = ($urandom_range(1, 100) <= mem_ready_pct);
    endtask

    task automatic cycle();
        @(negedge clk);
        s_req      = imem.Fo_imemReq;
        s_addr     = imem.Fo_imemAddr;
        s_ready    = imem.Fi_imemReady;
        s_rvalid   = imem.Fi_imemRvalid;
        s_redirect = ei_redirect | di_jal;
        s_target   = ei_redirect ? ei_target : di_jal_target;
        s_di_stall = di_stall;
        prev_busy  = mem_busy;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            if (s_rvalid) mem_busy = 1'b0;
            else if (mem_busy && mem_lat > 0) mem_lat--;
            if (s_req && s_ready) begin
                mem_busy = 1'b1;
                mem_addr = s_addr;
                mem_lat  = $urandom_range(0, mem_max_lat);
            end
            drive_mem();
        end
    endtask

    task automatic zero_wait_mem();
        mem_auto      = 1'b1;
        mem_ready_pct = 100;
        mem_max_lat   = 0;
        drive_mem();
    endtask

    task automatic do_reset();
        reset_x = 1'b0;
        {fi_stall, di_stall, di_flush, ei_redirect, di_jal} = '0;
        ei_target = '0;
        di_jal_target = '0;
        imem.Fi_imemReady  = 1'b0;
        imem.Fi_imemRvalid = 1'b0;
        imem.Fi_imemRdata  = '0;
        mem_auto = 1'b0;
        mem_busy = 1'b0;
        mem_lat  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_x = 1'b1;
    endtask

    task automatic test_reset();
        reset_x = 1'b0;
        {fi_stall, di_stall, di_flush, ei_redirect, di_jal} = '0;
        imem.Fi_imemReady  = 1'b1;
        imem.Fi_imemRvalid = 1'b0;
        imem.Fi_imemRdata  = '0;
        @(posedge clk);
        #1;
        total++;
        if ({imem.Fo_imemReq, imem.Fo_imemAddr} !== {1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_bus: req/addr=%b/%h want 0/00000000", imem.Fo_imemReq, imem.Fo_imemAddr);
        end
        total++;
        if ({do_valid, do_instr, do_pc, do_pc_plus4} !== {1'b0, NOP, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL reset_fd: v=%b instr=%h pc=%h pc4=%h want 0/%h/0/0", do_valid, do_instr, do_pc, do_pc_plus4, NOP);
        end
        @(posedge clk);
        #1;
        reset_x = 1'b1;
        #1;
        total++;
        if (imem.Fo_imemReq !== 1'b1) begin
            bad++;
            $display("FAIL first_req: req=%b want 1", imem.Fo_imemReq);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        zero_wait_mem();
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k % 2 == 0) begin
                total++;
                if ({s_req && s_ready, s_addr, do_valid} !== {1'b1, 32'(4 * (k / 2)), 1'b0}) begin
                    bad++;
                    $display("FAIL zw_req[%0d]: hs=%b addr=%h valid=%b want 1/%h/0", k, s_req && s_ready, s_addr, do_valid, 32'(4 * (k / 2)));
                end
            end else begin
                total++;
                if ({do_valid, do_pc, do_instr, do_pc_plus4} !==
                    {1'b1, 32'(4 * (k / 2)), tag(32'(4 * (k / 2))), 32'(4 * (k / 2) + 4)}) begin
                    bad++;
                    $display("FAIL zw_fd[%0d]: v=%b pc=%h instr=%h pc4=%h want pc=%h", k, do_valid, do_pc, do_instr, do_pc_plus4, 32'(4 * (k / 2)));
                end
            end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem.Fi_imemReady = 1'b1;
        cycle();
        imem.Fi_imemReady = 1'b0;
        ei_redirect = 1'b1;
        ei_target   = 32'h100;
        cycle();
        ei_redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            total++;
            if ({imem.Fo_imemReq, do_valid} !== 2'b00) begin
                bad++;
                $display("FAIL rw_drain[%0d]: req=%b valid=%b want 0/0", k, imem.Fo_imemReq, do_valid);
            end
        end
        imem.Fi_imemRvalid = 1'b1;
        imem.Fi_imemRdata  = tag(32'h0);
        cycle();
        imem.Fi_imemRvalid = 1'b0;
        total++;
        if ({do_valid, imem.Fo_imemReq, imem.Fo_imemAddr} !== {1'b0, 1'b1, 32'h100}) begin
            bad++;
            $display("FAIL rw_stale: valid=%b req=%b addr=%h want 0/1/00000100", do_valid, imem.Fo_imemReq, imem.Fo_imemAddr);
        end
        imem.Fi_imemReady = 1'b1;
        cycle();
        imem.Fi_imemReady  = 1'b0;
        imem.Fi_imemRvalid = 1'b1;
        imem.Fi_imemRdata  = tag(32'h100);
        cycle();
        imem.Fi_imemRvalid = 1'b0;
        total++;
        if ({do_valid, do_pc, do_instr} !== {1'b1, 32'h100, tag(32'h100)}) begin
            bad++;
            $display("FAIL rw_target: v=%b pc=%h instr=%h want 1/00000100/%h", do_valid, do_pc, do_instr, tag(32'h100));
        end
    endtask

    task automatic test_redirect_priority();
        do_reset();
        fi_stall      = 1'b1;
        ei_redirect   = 1'b1;
        ei_target     = 32'h200;
        di_jal        = 1'b1;
        di_jal_target = 32'h300;
        cycle();
        {ei_redirect, di_jal, fi_stall} = '0;
        #1;
        total++;
        if ({imem.Fo_imemReq, imem.Fo_imemAddr} !== {1'b1, 32'h200}) begin
            bad++;
            $display("FAIL prio_e_wins: req=%b addr=%h want 1/00000200", imem.Fo_imemReq, imem.Fo_imemAddr);
        end
        fi_stall      = 1'b1;
        di_jal        = 1'b1;
        di_jal_target = 32'h30A;
        cycle();
        {di_jal, fi_stall} = '0;
        #1;
        total++;
        if (imem.Fo_imemAddr !== 32'h308) begin
            bad++;
            $display("FAIL jal_unaligned_addr: addr=%h want 00000308", imem.Fo_imemAddr);
        end
        imem.Fi_imemReady = 1'b1;
        cycle();
        imem.Fi_imemReady  = 1'b0;
        imem.Fi_imemRvalid = 1'b1;
        imem.Fi_imemRdata  = tag(32'h308);
        cycle();
        imem.Fi_imemRvalid = 1'b0;
        total++;
        if ({do_valid, do_pc, do_pc_plus4, do_instr} !== {1'b1, 32'h30A, 32'h30E, tag(32'h308)}) begin
            bad++;
            $display("FAIL jal_fd: v=%b pc=%h pc4=%h instr=%h want 1/0000030a/0000030e", do_valid, do_pc, do_pc_plus4, do_instr);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        zero_wait_mem();
        repeat (4) cycle();
        di_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++;
            if ({do_valid, do_pc, do_instr, do_pc_plus4, imem.Fo_imemReq} !==
                {1'b1, 32'h4, tag(32'h4), 32'h8, 1'b0}) begin
                bad++;
                $display("FAIL stall_frozen[%0d]: v=%b pc=%h instr=%h pc4=%h req=%b want pc=4", k, do_valid, do_pc, do_instr, do_pc_plus4, imem.Fo_imemReq);
            end
        end
        di_stall = 1'b0;
        cycle();
        total++;
        if ({do_valid, do_pc, do_instr, do_pc_plus4} !== {1'b1, 32'h8, tag(32'h8), 32'hC}) begin
            bad++;
            $display("FAIL hold_release: v=%b pc=%h instr=%h pc4=%h want 1/00000008", do_valid, do_pc, do_instr, do_pc_plus4);
        end
        total++;
        if ({imem.Fo_imemReq, imem.Fo_imemAddr} !== {1'b1, 32'hC}) begin
            bad++;
            $display("FAIL hold_next_addr: req=%b addr=%h want 1/0000000c", imem.Fo_imemReq, imem.Fo_imemAddr);
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        zero_wait_mem();
        repeat (2) cycle();
        di_flush = 1'b1;
        di_stall = 1'b1;
        cycle();
        {di_flush, di_stall} = '0;
        total++;
        if ({do_valid, do_instr} !== {1'b0, NOP}) begin
            bad++;
            $display("FAIL flush_over_stall: v=%b instr=%h want 0/%h", do_valid, do_instr, NOP);
        end
        cycle();
        total++;
        if ({do_valid, do_pc} !== {1'b1, 32'h4}) begin
            bad++;
            $display("FAIL after_flush: v=%b pc=%h want 1/00000004", do_valid, do_pc);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        zero_wait_mem();
        cycle();
        mem_auto = 1'b0;
        imem.Fi_imemReady  = 1'b0;
        imem.Fi_imemRvalid = 1'b0;
        reset_x = 1'b0;
        #1;
        total++;
        if ({imem.Fo_imemReq, do_valid} !== 2'b00) begin
            bad++;
            $display("FAIL midreset_async: req=%b valid=%b want 0/0", imem.Fo_imemReq, do_valid);
        end
        repeat (2) cycle();
        reset_x = 1'b1;
        imem.Fi_imemRvalid = 1'b1;
        imem.Fi_imemRdata  = 32'hDEAD_BEEF;
        cycle();
        imem.Fi_imemRvalid = 1'b0;
        total++;
        if ({do_valid, do_instr, imem.Fo_imemReq, imem.Fo_imemAddr} !== {1'b0, NOP, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL midreset_ignore: v=%b instr=%h req=%b addr=%h want 0/%h/1/0", do_valid, do_instr, imem.Fo_imemReq, imem.Fo_imemAddr, NOP);
        end
        imem.Fi_imemReady = 1'b1;
        cycle();
        imem.Fi_imemReady  = 1'b0;
        imem.Fi_imemRvalid = 1'b1;
        imem.Fi_imemRdata  = tag(32'h0);
        cycle();
        imem.Fi_imemRvalid = 1'b0;
        total++;
        if ({do_valid, do_pc, do_instr} !== {1'b1, 32'h0, tag(32'h0)}) begin
            bad++;
            $display("FAIL midreset_refetch: v=%b pc=%h instr=%h want 1/0/%h", do_valid, do_pc, do_instr, tag(32'h0));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        fi_stall    = 1'b1;
        ei_redirect = 1'b1;
        ei_target   = 32'hFFFF_FFFC;
        cycle();
        {ei_redirect, fi_stall} = '0;
        zero_wait_mem();
        cycle();
        total++;
        if ({s_req && s_ready, s_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            bad++;
            $display("FAIL wrap_req: hs=%b addr=%h want 1/fffffffc", s_req && s_ready, s_addr);
        end
        cycle();
        total++;
        if ({do_valid, do_pc, do_pc_plus4, imem.Fo_imemAddr} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL wrap_fd: v=%b pc=%h pc4=%h next=%h want 1/fffffffc/0/0", do_valid, do_pc, do_pc_plus4, imem.Fo_imemAddr);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic        m_valid;
        logic [31:0] m_pc, m_pc4, m_instr;
        int          dcount, resp;
        do_reset();
        mem_auto      = 1'b1;
        mem_ready_pct = 60;
        mem_max_lat   = 3;
        drive_mem();
        exp_pc  = 32'h0;
        m_valid = 1'b0;
        m_pc    = 32'h0;
        m_pc4   = 32'h0;
        m_instr = NOP;
        dcount  = 0;
        resp    = 0;
        for (int n = 0; n < 600; n++) begin
            fi_stall      = ($urandom_range(1, 100) <= 20);
            di_stall      = ($urandom_range(1, 100) <= 25);
            ei_redirect   = ($urandom_range(1, 100) <= 8);
            di_jal        = ($urandom_range(1, 100) <= 8);
            ei_target     = {16'h0, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFD;
            di_jal_target = {16'h1, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFC;
            cycle();
            total++;
            if (s_req && prev_busy) begin
                bad++;
                $display("FAIL rnd_outstanding[%0d]: request issued with one already pending", n);
            end
            if (s_req && s_ready) begin
                total++;
                if (s_addr !== {exp_pc[31:2], 2'b00}) begin
                    bad++;
                    $display("FAIL rnd_addr[%0d]: addr=%h want %h", n, s_addr, {exp_pc[31:2], 2'b00});
                end
            end
            if (s_rvalid) resp++;
            if (s_di_stall) begin
                total++;
                if ({do_valid, do_instr} !== {m_valid, m_instr} ||
                    (m_valid && {do_pc, do_pc_plus4} !== {m_pc, m_pc4})) begin
                    bad++;
                    $display("FAIL rnd_stall[%0d]: v=%b pc=%h instr=%h want v=%b pc=%h instr=%h", n, do_valid, do_pc, do_instr, m_valid, m_pc, m_instr);
                end
            end else if (do_valid) begin
                dcount++;
                m_valid = 1'b1;
                m_pc    = exp_pc;
                m_pc4   = exp_pc + 32'd4;
                m_instr = tag({exp_pc[31:2], 2'b00});
                total++;
                if ({do_pc, do_pc_plus4, do_instr} !== {m_pc, m_pc4, m_instr} || dcount > resp) begin
                    bad++;
                    $display("FAIL rnd_deliver[%0d]: pc=%h pc4=%h instr=%h want %h/%h/%h (dcount=%0d resp=%0d)", n, do_pc, do_pc_plus4, do_instr, m_pc, m_pc4, m_instr, dcount, resp);
                end
                exp_pc = exp_pc + 32'd4;
            end else begin
                m_valid = 1'b0;
                m_instr = NOP;
                total++;
                if (do_instr !== NOP) begin
                    bad++;
                    $display("FAIL rnd_bubble[%0d]: instr=%h want %h", n, do_instr, NOP);
                end
            end
            if (s_redirect) exp_pc = s_target;
        end
        {fi_stall, di_stall, ei_redirect, di_jal} = '0;
        total++;
        if (dcount < 10) begin
            bad++;
            $display("FAIL rnd_progress: deliveries=%0d want >=10", dcount);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_redirect_wait();
        test_redirect_priority();
        test_stall_hold();
        test_flush_stall();
        test_reset_midop();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
